rr_select_arbiter: RTL and testbench

RR_SELECT_ARBITER -- requirements
Module: rr_select_arbiter

---
 rtl/rr_select_arbiter.sv | 119 +++++++++++
 tb/tb_rr_select_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_select_arbiter.sv
// Four-source round-robin arbiter driving a 4:1 mux select (address1:address0).
// Optional forced release after HOLD_MAX grant cycles: define RR_SELECT_ARBITER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant; select lines hold the last granted index
// GRANT | one source owns the mux until done, request drop, or hold limit
module rr_select_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       address0,
  output logic       address1,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] pick_idx;
  logic       pick_ok;
  logic       rel_normal;
  logic       limit;
  logic       fire_to;

  // First set request bit starting at p and walking upward modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      cand = p + 2'(k);
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  assign {pick_ok, pick_idx} = rr_pick(req, ptr_q);
  assign rel_normal = done | ~req[idx_q];

`ifdef RR_SELECT_ARBITER_TIMEOUT_EN
  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX - 1);

  logic [3:0] cnt_q;
  logic       timeout_q;

  // cnt_q counts completed grant cycles; the limit hits in the HOLD_MAX-th cycle.
  assign limit = (cnt_q == HOLD_LIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= fire_to;
      if (state_q == IDLE || state_d == IDLE) cnt_q <= 4'd0;
      else                                    cnt_q <= cnt_q + 4'd1;
    end
  end

  assign timeout = timeout_q;
`else
  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX - 1);
  logic unused_hold;

  assign unused_hold = ^{HOLD_LIM, fire_to};
  assign limit       = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    fire_to = 1'b0;
    case (state_q)
      IDLE: begin
        // done is meaningless here; only requests start a grant
        if (pick_ok) begin
          state_d = GRANT;
          idx_d   = pick_idx;
        end
      end
      GRANT: begin
        if (rel_normal || limit) begin
          state_d = IDLE;
          ptr_d   = idx_q + 2'd1;
          fire_to = ~rel_normal & limit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  // Select lines come straight from the held index so the mux never glitches in IDLE.
  assign address0    = idx_q[0];
  assign address1    = idx_q[1];
  assign grant_valid = (state_q == GRANT);
  assign grant       = grant_valid ? (4'b0001 << idx_q) : 4'b0000;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Self-checking bench for rr_select_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_rr_select_arbiter;
  localparam int HOLD_MAX = 8;
`ifdef RR_SELECT_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic       address0, address1, grant_valid, timeout;
  logic [3:0] grant;

  int passed = 0;
  int total  = 0;

  // Model: m_busy/m_owner describe the current grant, m_held counts its cycles.
  bit m_busy;
  int m_owner, m_ptr, m_addr, m_held;
  bit m_timeout;

  rr_select_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .address0(address0), .address1(address1), .grant(grant),
    .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic d, input logic rn);
    int pick;
    bit normal;
    if (!rn) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_addr = 0; m_held = 0; m_timeout = 0;
    end else if (!m_busy) begin
      m_timeout = 0;
      pick = first_from(r, m_ptr);
      if (pick >= 0) begin
        m_busy = 1; m_owner = pick; m_addr = pick; m_held = 1;
      end
    end else begin
      m_timeout = 0;
      normal = d || !r[m_owner];
      if (normal || (TO_EN && m_held >= HOLD_MAX)) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % 4;
        m_timeout = !normal;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic tick(input logic [3:0] r, input logic d, input logic rn);
    req = r; done = d; rst_n = rn;
    @(posedge clk);
    model_step(r, d, rn);
    #1;
  endtask

  task automatic test_reset();
    tick(4'b1111, 1'b1, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    total++;
    if ({grant, grant_valid, address1, address0, timeout} !== 8'h00)
      $display("FAIL reset_outputs got grant=%b gv=%b addr=%b%b to=%b want all 0",
               grant, grant_valid, address1, address0, timeout);
    else passed++;
  endtask

  task automatic test_alternate();
    int exp_seq[4] = '{1, 3, 1, 3};
    tick(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(4'b1010, 1'b0, 1'b1);
      total++;
      if (grant !== (4'b0001 << exp_seq[i]) || {address1, address0} !== 2'(exp_seq[i]) || !grant_valid)
        $display("FAIL alternate_grant[%0d] got grant=%b addr=%b%b want source %0d", i, grant, address1, address0, exp_seq[i]);
      else passed++;
      tick(4'b1010, 1'b1, 1'b1);
      total++;
      if (grant_valid !== 1'b0 || grant !== 4'b0000 || {address1, address0} !== 2'(exp_seq[i]))
        $display("FAIL alternate_idle[%0d] got gv=%b grant=%b addr=%b%b want idle holding %0d",
                 i, grant_valid, grant, address1, address0, exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    tick(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(4'b1111, 1'b0, 1'b1);
      total++;
      if (grant !== (4'b0001 << exp_seq[i]) || {address1, address0} !== 2'(exp_seq[i]))
        $display("FAIL wrap_grant[%0d] got grant=%b addr=%b%b want source %0d", i, grant, address1, address0, exp_seq[i]);
      else passed++;
      tick(4'b1111, 1'b1, 1'b1);
    end
  endtask

  task automatic test_stable();
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick((i % 2 == 0) ? 4'b1101 : 4'b0100, 1'b0, 1'b1);
      total++;
      if (grant !== 4'b0100 || {address1, address0} !== 2'b10 || !grant_valid)
        $display("FAIL stable_hold[%0d] got grant=%b addr=%b%b want 0100/10", i, grant, address1, address0);
      else passed++;
    end
    tick(4'b1101, 1'b1, 1'b1);
    total++;
    if (grant_valid !== 1'b0) $display("FAIL stable_release got gv=%b want 0", grant_valid);
    else passed++;
  endtask

  task automatic test_drop();
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b1);
    tick(4'b0000, 1'b0, 1'b1);
    total++;
    if (grant_valid !== 1'b0 || grant !== 4'b0000)
      $display("FAIL drop_release got gv=%b grant=%b want 0/0000", grant_valid, grant);
    else passed++;
    tick(4'b1111, 1'b0, 1'b1);
    total++;
    if (grant !== 4'b0100) $display("FAIL drop_ptr got grant=%b want 0100", grant);
    else passed++;
  endtask

  task automatic test_reset_mid();
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b1);
    tick(4'b0100, 1'b0, 1'b0);
    total++;
    if ({grant, grant_valid, address1, address0, timeout} !== 8'h00)
      $display("FAIL reset_mid got grant=%b gv=%b addr=%b%b want all 0", grant, grant_valid, address1, address0);
    else passed++;
    tick(4'b0101, 1'b0, 1'b1);
    total++;
    if (grant !== 4'b0001 || {address1, address0} !== 2'b00)
      $display("FAIL reset_first got grant=%b addr=%b%b want 0001/00", grant, address1, address0);
    else passed++;
  endtask

  task automatic test_timeout();
    int cycles;
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0001, 1'b0, 1'b1);
    cycles = 0;
    while (grant_valid && cycles < 130) begin
      cycles++;
      total++;
      if (timeout !== 1'b0) $display("FAIL timeout_early at grant cycle %0d got 1 want 0", cycles);
      else passed++;
      tick(4'b0001, 1'b0, 1'b1);
    end
    if (TO_EN) begin
      total++;
      if (cycles !== HOLD_MAX) $display("FAIL timeout_hold got %0d grant cycles want %0d", cycles, HOLD_MAX);
      else passed++;
      total++;
      if (timeout !== 1'b1 || grant_valid !== 1'b0)
        $display("FAIL timeout_pulse got to=%b gv=%b want 1/0", timeout, grant_valid);
      else passed++;
      tick(4'b0001, 1'b0, 1'b1);
      total++;
      if (timeout !== 1'b0 || grant !== 4'b0001)
        $display("FAIL timeout_regrant got to=%b grant=%b want 0/0001", timeout, grant);
      else passed++;
      for (int i = 1; i < HOLD_MAX; i++) tick(4'b0001, 1'b0, 1'b1);
      tick(4'b0001, 1'b1, 1'b1);
      total++;
      if (timeout !== 1'b0 || grant_valid !== 1'b0)
        $display("FAIL timeout_done_tie got to=%b gv=%b want 0/0", timeout, grant_valid);
      else passed++;
    end else begin
      total++;
      if (cycles < 100) $display("FAIL hold_forever got %0d grant cycles want >=100", cycles);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic d, rn;
    int bad = 0;
    tick(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      r  = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 3) == 0);
      rn = ($urandom_range(0, 99) != 0);
      tick(r, d, rn);
      total++;
      if (grant !== (m_busy ? 4'(1 << m_owner) : 4'b0000) || grant_valid !== m_busy ||
          {address1, address0} !== 2'(m_addr) || timeout !== m_timeout || $countones(grant) > 1) begin
        if (bad < 10)
          $display("FAIL random[%0d] got grant=%b gv=%b addr=%b%b to=%b want grant=%b gv=%b addr=%0d to=%b",
                   i, grant, grant_valid, address1, address0, timeout,
                   m_busy ? 4'(1 << m_owner) : 4'b0000, m_busy, m_addr, m_timeout);
        bad++;
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_wrap();
    test_stable();
    test_drop();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
